// File: rtl/turbo_iter_scheduler.sv
// Half-iteration sequencer for a shared SISO engine: alternates natural/interleaved order,
// guards each half-iteration with a watchdog and records per-block decode latency.
module turbo_iter_scheduler #(
    parameter int unsigned ITER_W  = 4,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned LAT_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              abort,
    input  logic              siso_done,
    output logic              siso_start,
    output logic              siso_interleave,
    output logic [ITER_W:0]   half_iter,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [LAT_W-1:0]  last_latency
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [ITER_W-1:0] n_iter_q, n_iter_d;
    logic [ITER_W-1:0] n_eff;
    logic [ITER_W:0]   half_q, half_d, last_half;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d, lat_inc;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              terr_q, terr_d;
    logic              siso_start_q, done_q, busy_q;

    assign n_eff     = (n_iter_q == '0) ? ITER_W'(1) : n_iter_q;
    assign last_half = {n_eff, 1'b0} - (ITER_W + 1)'(1);
    // lat_cnt_q counts busy cycles up to and including the current one; saturates
    assign lat_inc   = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

    always_comb begin
        state_d   = state_q;
        n_iter_d  = n_iter_q;
        half_d    = half_q;
        wait_d    = wait_q;
        lat_cnt_d = lat_cnt_q;
        lat_d     = lat_q;
        terr_d    = terr_q;

        if (state_q != S_IDLE) begin
            lat_cnt_d = lat_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LAUNCH;
                    n_iter_d  = n_iter;
                    half_d    = '0;
                    terr_d    = 1'b0;
                    lat_cnt_d = LAT_W'(1);
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (siso_done) begin
                    if (half_q == last_half) begin
                        state_d = S_FINISH;
                    end else begin
                        half_d  = half_q + (ITER_W + 1)'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_FINISH, S_ERR: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase

        // Abort overrides both a same-cycle engine done and a watchdog expiry
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            half_d  = half_q;
        end

        if (state_d == S_FINISH || state_d == S_ERR) begin
            lat_d = lat_inc;
        end
        if (state_d == S_ERR) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_iter_q     <= '0;
            half_q       <= '0;
            wait_q       <= '0;
            lat_cnt_q    <= '0;
            lat_q        <= '0;
            terr_q       <= 1'b0;
            siso_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_iter_q     <= n_iter_d;
            half_q       <= half_d;
            wait_q       <= wait_d;
            lat_cnt_q    <= lat_cnt_d;
            lat_q        <= lat_d;
            terr_q       <= terr_d;
            siso_start_q <= (state_q == S_LAUNCH) && (state_d == S_WAIT);
            done_q       <= (state_d == S_FINISH) || (state_d == S_ERR);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign siso_start      = siso_start_q;
    assign siso_interleave = half_q[0];
    assign half_iter       = half_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout_err     = terr_q;
    assign last_latency    = lat_q;

endmodule
